// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with sync and
// display-enable outputs delayed to line up with the renderers' output register.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Delay-stage reset value: {blank, hs, vs} = idle, sync deasserted.
  localparam logic [2:0] PIPE_IDLE = 3'b011;

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       h_wrap;
  logic       blank_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic [PIPE_DELAY-1:0][2:0] pipe;

  // Next-count logic; vc advances (and wraps) only on the hc wrap edge.
  always_comb begin
    h_wrap  = (hc == H_LAST);
    hc_next = hc + 10'd1;
    vc_next = vc;
    if (h_wrap) begin
      hc_next = 10'd0;
      if (vc == V_LAST) begin
        vc_next = 10'd0;
      end else begin
        vc_next = vc + 10'd1;
      end
    end else begin
      vc_next = vc;
    end
  end

  // Raster counters.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else begin
      hc <= hc_next;
      vc <= vc_next;
    end
  end

  // Undelayed display-enable and active-low sync decodes.
  always_comb begin
    blank_raw = (hc < H_VIS) && (vc < V_VIS);
    hs_raw    = !((hc >= H_SYNC_BEG) && (hc < H_SYNC_END));
    vs_raw    = !((vc >= V_SYNC_BEG) && (vc < V_SYNC_END));
  end

  // Delay line so blank/hs/vs meet the pixel data for the same coordinate.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe[i] <= PIPE_IDLE;
      end
    end else begin
      pipe[0] <= {blank_raw, hs_raw, vs_raw};
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = pipe[PIPE_DELAY-1][2];
  assign hs          = pipe[PIPE_DELAY-1][1];
  assign vs          = pipe[PIPE_DELAY-1][0];
  assign line_start  = (hc == 10'd0);
  assign frame_start = (hc == 10'd0) && (vc == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a raster model computed from the cycle
// count feeds an expectation queue; a negedge monitor compares and measures pulses.
module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 24,  VF = 3,  VS = 2,  VB = 4;
  localparam int PD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam longint FRAME = longint'(HT) * longint'(VT);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
  } exp_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, frame_start, line_start;

  int     errors = 0;
  int     checks = 0;
  longint t = 0;
  exp_t   exp_q[$];

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .hs(hs), .vs(vs),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 vga_clk = ~vga_clk;

  // Expected outputs n cycles after reset release: position from the cycle count,
  // delayed terms from the position PD cycles earlier (idle values before that).
  function automatic exp_t model(input longint n);
    exp_t   e;
    longint x, y, xd, yd;
    x = n % HT;
    y = (n / HT) % VT;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.fs = (x == 0) && (y == 0);
    e.ls = (x == 0);
    if (n < PD) begin
      e.blank = 1'b0; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      xd = (n - PD) % HT;
      yd = ((n - PD) / HT) % VT;
      e.blank = (xd < HV) && (yd < VV);
      e.hs    = !((xd >= HV + HF) && (xd < HV + HF + HS));
      e.vs    = !((yd >= VV + VF) && (yd < VV + VF + VS));
    end
    return e;
  endfunction

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // act: 0 = run, 1 = assert reset mid-cycle, 2 = release reset mid-cycle
  task automatic step(input int act);
    @(posedge vga_clk);
    #1;
    if (reset_n) t++; else t = 0;
    if (act == 1) begin
      #1; reset_n = 1'b0; t = 0;
    end else if (act == 2) begin
      #1; reset_n = 1'b1;
    end
    exp_q.push_back(model(t));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  initial begin : driver
    int hold;
    hold = int'($urandom_range(2, 6));
    for (int i = 0; i < hold; i++) step(0);
    step(2);
    run(int'(2 * FRAME) + 1000);
    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(500, 4000)));
      step(1);
      run(2);
      step(2);
    end
    run(2000);
    @(negedge vga_clk);
    #1;
    chk("sb_leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : monitor
    exp_t   a, e;
    longint mc = 0;
    longint hs_fall = -1, vs_fall = -1, fs_at = -1;
    longint hs_low = 0, vs_low = 0, line_cnt = 0;
    logic   prev_hs = 1'b1, prev_vs = 1'b1, prev_blank = 1'b0, line_valid = 1'b0;
    int     line_y = 0;
    forever begin
      @(negedge vga_clk);
      mc++;
      a.x = DrawX; a.y = DrawY; a.blank = blank; a.hs = hs; a.vs = vs;
      a.fs = frame_start; a.ls = line_start;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard: got x=%0d y=%0d b=%b hs=%b vs=%b fs=%b ls=%b expected x=%0d y=%0d b=%b hs=%b vs=%b fs=%b ls=%b",
                   a.x, a.y, a.blank, a.hs, a.vs, a.fs, a.ls,
                   e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.ls);
        end
      end
      if (!reset_n) begin
        hs_fall = -1; vs_fall = -1; fs_at = -1; line_valid = 1'b0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_blank = 1'b0;
      end else begin
        if (prev_hs && !hs) begin
          chk("hs_fall_x", DrawX, HV + HF + PD);
          if (hs_fall >= 0) chk("hs_period", mc - hs_fall, HT);
          hs_fall = mc; hs_low = 0;
        end
        if (!hs) hs_low++;
        if (!prev_hs && hs && hs_fall >= 0) chk("hs_low_width", hs_low, HS);
        if (prev_vs && !vs) begin
          chk("vs_fall_x", DrawX, PD);
          chk("vs_fall_y", DrawY, VV + VF);
          if (vs_fall >= 0) chk("vs_period", mc - vs_fall, FRAME);
          vs_fall = mc; vs_low = 0;
        end
        if (!vs) vs_low++;
        if (!prev_vs && vs && vs_fall >= 0) chk("vs_low_width", vs_low, longint'(VS) * HT);
        if (!prev_blank && blank) chk("blank_rise_x", DrawX, PD);
        if (frame_start) begin
          if (fs_at >= 0) chk("frame_period", mc - fs_at, FRAME);
          fs_at = mc;
        end
        if (line_start) begin
          if (line_valid) chk("blank_per_line", line_cnt, (line_y < VV) ? HV : 0);
          line_valid = 1'b1; line_y = int'(DrawY); line_cnt = 0;
        end
        if (blank) line_cnt++;
        prev_hs = hs; prev_vs = vs; prev_blank = blank;
      end
    end
  end

endmodule
